// File: rtl/rw_step_arbiter.sv
// rw_step_arbiter
//
// Round-robin session arbiter that shares one stateful byte-stream device
// among N requesters. A session is granted to one requester, the device is
// restarted for one cycle, and then the winner's bytes are streamed into the
// device one per cycle. Each device output byte is registered and returned to
// the winner.
//
// Ports:
//   clk         system clock, shared with the device
//   rst         asynchronous active-high reset
//   req_valid   per-requester byte-valid
//   req_data    packed request bytes, requester i on [8i+7:8i]
//   req_ready   one-hot, byte from requester i accepted when valid & ready
//   grant       one-hot owner of the current session, 0 when idle
//   resp_valid  one-hot, resp_data belongs to requester i
//   resp_data   registered device output byte
//   busy        session in progress
//   dev_rst     registered reset to the device
//   dev_in      device input byte, 0 when nothing is accepted
//   dev_out     device output byte, combinational from dev_in and its state
module rw_step_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic [N-1:0]     grant,
  output logic [N-1:0]     resp_valid,
  output logic [7:0]       resp_data,
  output logic             busy,
  output logic             dev_rst,
  output logic [7:0]       dev_in,
  input  logic [7:0]       dev_out
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RESTART,
    STREAM
  } state_t;

  state_t         state, state_next;
  logic [IW-1:0]  ptr, ptr_next;
  logic [IW-1:0]  gidx, gidx_next;
  logic [IW-1:0]  pick;
  logic [N-1:0]   grant_next;
  logic [7:0]     cnt, cnt_next;
  logic           dev_rst_next;
  logic           found;
  logic           accept;
  logic           last;
  logic [7:0]     gdata;

  // Round-robin search: first requester at or after ptr, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        pick  = IW'((int'(ptr) + k) % N);
      end
    end
  end

  // Byte acceptance and the device input. The device advances every clock,
  // so dev_in is forced to zero whenever no byte is taken.
  always_comb begin
    gdata     = req_data[8*gidx +: 8];
    accept    = (state == STREAM) && req_valid[gidx];
    last      = accept && ((cnt + 8'd1) == 8'(MAX_BURST));
    req_ready = accept ? grant : '0;
    dev_in    = accept ? gdata : 8'h00;
    busy      = (state != IDLE);
  end

  // Next-state logic. A dropped valid ends the session; the burst limit ends
  // it on the cycle the final byte is accepted. The pointer always moves one
  // past the finishing requester so every requester gets a turn.
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    gidx_next    = gidx;
    grant_next   = grant;
    cnt_next     = cnt;
    dev_rst_next = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_next       = RESTART;
          gidx_next        = pick;
          grant_next       = '0;
          grant_next[pick] = 1'b1;
          dev_rst_next     = 1'b1;
        end
      end
      RESTART: begin
        state_next = STREAM;
      end
      STREAM: begin
        if (accept) begin
          cnt_next = cnt + 8'd1;
        end
        if (!req_valid[gidx] || last) begin
          state_next = IDLE;
          grant_next = '0;
          cnt_next   = '0;
          ptr_next   = (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register. dev_rst comes straight from a flop so the device sees a
  // glitch-free reset, and it is held high while the arbiter is in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gidx    <= '0;
      grant   <= '0;
      cnt     <= '0;
      dev_rst <= 1'b1;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      gidx    <= gidx_next;
      grant   <= grant_next;
      cnt     <= cnt_next;
      dev_rst <= dev_rst_next;
    end
  end

  // Response register: capture the device output on each accepted byte;
  // otherwise the valid drops and the data holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= '0;
      resp_data  <= 8'h00;
    end else if (accept) begin
      resp_valid <= grant;
      resp_data  <= dev_out;
    end else begin
      resp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_rw_step_arbiter.sv
// tb_rw_step_arbiter
//
// Directed bench for rw_step_arbiter. Two instances share clock and reset:
// dut (MAX_BURST=16) and dut3 (MAX_BURST=3). Each has a small behavioural
// device: state resets to 8'h3C, out = state ^ in, next state = rol(state)+in.
module tb_rw_step_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic [3:0]  req_valid, req_ready, grant, resp_valid;
  logic [31:0] req_data;
  logic [7:0]  resp_data, dev_in, dev_out, dev_state;
  logic        busy, dev_rst;

  logic [3:0]  rv3, rr3, grant3, resp_valid3;
  logic [31:0] rd3;
  logic [7:0]  resp_data3, dev_in3, dev_out3, dev_state3;
  logic        busy3, dev_rst3;

  int errors = 0;
  int checks = 0;

  rw_step_arbiter #(.N(4), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant(grant), .resp_valid(resp_valid),
    .resp_data(resp_data), .busy(busy), .dev_rst(dev_rst),
    .dev_in(dev_in), .dev_out(dev_out)
  );

  rw_step_arbiter #(.N(4), .MAX_BURST(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_data(rd3),
    .req_ready(rr3), .grant(grant3), .resp_valid(resp_valid3),
    .resp_data(resp_data3), .busy(busy3), .dev_rst(dev_rst3),
    .dev_in(dev_in3), .dev_out(dev_out3)
  );

  // Behavioural devices, asynchronously reset by the arbiter's dev_rst.
  always_ff @(posedge clk or posedge dev_rst) begin
    if (dev_rst) dev_state <= 8'h3C;
    else         dev_state <= {dev_state[6:0], dev_state[7]} + dev_in;
  end
  assign dev_out = dev_state ^ dev_in;

  always_ff @(posedge clk or posedge dev_rst3) begin
    if (dev_rst3) dev_state3 <= 8'h3C;
    else          dev_state3 <= {dev_state3[6:0], dev_state3[7]} + dev_in3;
  end
  assign dev_out3 = dev_state3 ^ dev_in3;

  // Reset values while rst is held, then dev_rst falls at the first edge.
  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_data = '0; rv3 = '0; rd3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 0000", resp_valid); end
    checks++; if (resp_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_resp_data: got %h expected 00", resp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (dev_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset_dev_rst: got %b expected 1", dev_rst); end
    checks++; if (dev_rst3 !== 1'b1) begin errors++; $display("[TB] FAIL reset_dev_rst3: got %b expected 1", dev_rst3); end
    checks++; if (dev_in !== 8'h00) begin errors++; $display("[TB] FAIL reset_dev_in: got %h expected 00", dev_in); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (dev_rst !== 1'b0) begin errors++; $display("[TB] FAIL release_dev_rst: got %b expected 0", dev_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL release_busy: got %b expected 0", busy); end
  endtask

  // Requester 0 streams 8'h10..8'h14 then drops valid.
  task automatic test_single();
    logic [7:0] exp_resp [5];
    logic [3:0] eg, eacc, erv;
    logic [7:0] ein;
    exp_resp = '{8'h2C, 8'h99, 8'h30, 8'h45, 8'hAB};
    for (int c = 0; c < 10; c++) begin
      req_valid = (c <= 6) ? 4'b0001 : 4'b0000;
      req_data  = {24'h0, 8'h10 + 8'((c >= 2) ? c - 2 : 0)};
      @(negedge clk);
      eg   = (c >= 1 && c <= 7) ? 4'b0001 : 4'b0000;
      eacc = (c >= 2 && c <= 6) ? 4'b0001 : 4'b0000;
      ein  = (c >= 2 && c <= 6) ? 8'h10 + 8'(c - 2) : 8'h00;
      erv  = (c >= 3 && c <= 7) ? 4'b0001 : 4'b0000;
      checks++; if (grant !== eg) begin errors++; $display("[TB] FAIL single_grant c%0d: got %b expected %b", c, grant, eg); end
      checks++; if (dev_rst !== (c == 1)) begin errors++; $display("[TB] FAIL single_dev_rst c%0d: got %b expected %b", c, dev_rst, (c == 1)); end
      checks++; if ((req_ready & req_valid) !== eacc) begin errors++; $display("[TB] FAIL single_accept c%0d: got %b expected %b", c, req_ready & req_valid, eacc); end
      checks++; if (dev_in !== ein) begin errors++; $display("[TB] FAIL single_dev_in c%0d: got %h expected %h", c, dev_in, ein); end
      checks++; if (resp_valid !== erv) begin errors++; $display("[TB] FAIL single_resp_valid c%0d: got %b expected %b", c, resp_valid, erv); end
      if (c >= 3 && c <= 7) begin
        checks++; if (resp_data !== exp_resp[c-3]) begin errors++; $display("[TB] FAIL single_resp_data c%0d: got %h expected %h", c, resp_data, exp_resp[c-3]); end
      end
      if (c == 8) begin
        checks++; if (resp_data !== 8'hAB) begin errors++; $display("[TB] FAIL single_resp_hold: got %h expected ab", resp_data); end
      end
      checks++; if (busy !== (c >= 1 && c <= 7)) begin errors++; $display("[TB] FAIL single_busy c%0d: got %b expected %b", c, busy, (c >= 1 && c <= 7)); end
      @(posedge clk); #1;
    end
  endtask

  // All four requesters continuously on dut3 (MAX_BURST=3): 5-cycle period.
  task automatic test_round_robin();
    logic [3:0] eg, eacc;
    logic [7:0] ein;
    int phase, sess;
    rd3 = 32'h40302010;
    for (int c = 0; c < 26; c++) begin
      rv3 = (c <= 24) ? 4'hF : 4'h0;
      @(negedge clk);
      phase = c % 5;
      sess  = c / 5;
      eg    = (phase != 0) ? 4'(1 << (sess % 4)) : 4'b0000;
      eacc  = (phase >= 2) ? eg : 4'b0000;
      ein   = (phase >= 2) ? 8'(8'h10 * ((sess % 4) + 1)) : 8'h00;
      checks++; if (grant3 !== eg) begin errors++; $display("[TB] FAIL rr_grant c%0d: got %b expected %b", c, grant3, eg); end
      checks++; if ((rr3 & rv3) !== eacc) begin errors++; $display("[TB] FAIL rr_accept c%0d: got %b expected %b", c, rr3 & rv3, eacc); end
      checks++; if (dev_in3 !== ein) begin errors++; $display("[TB] FAIL rr_dev_in c%0d: got %h expected %h", c, dev_in3, ein); end
      checks++; if (dev_rst3 !== (phase == 1)) begin errors++; $display("[TB] FAIL rr_dev_rst c%0d: got %b expected %b", c, dev_rst3, (phase == 1)); end
      checks++; if (busy3 !== (phase != 0)) begin errors++; $display("[TB] FAIL rr_busy c%0d: got %b expected %b", c, busy3, (phase != 0)); end
      @(posedge clk); #1;
    end
  endtask

  // ptr=1 after requester 0's session. Requester 1 runs, then 0 and 2
  // request together while 1 is dropping: 2 wins, and not until IDLE passes.
  task automatic test_fairness();
    req_data = 32'h33221100;
    for (int c = 0; c < 9; c++) begin
      req_valid[1] = (c <= 3);
      req_valid[0] = (c >= 4 && c <= 6);
      req_valid[2] = (c >= 4 && c <= 6);
      req_valid[3] = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL fair_grant1: got %b expected 0010", grant); end
      end
      if (c == 2 || c == 3) begin
        checks++; if ((req_ready & req_valid) !== 4'b0010) begin errors++; $display("[TB] FAIL fair_accept1 c%0d: got %b expected 0010", c, req_ready & req_valid); end
      end
      if (c == 4) begin
        checks++; if ((req_ready & req_valid) !== 4'b0000) begin errors++; $display("[TB] FAIL fair_drop_accept: got %b expected 0000", req_ready & req_valid); end
      end
      if (c == 5) begin
        checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL fair_gap_grant: got %b expected 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL fair_gap_busy: got %b expected 0", busy); end
      end
      if (c == 6) begin
        checks++; if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL fair_grant2: got %b expected 0100", grant); end
        checks++; if (dev_rst !== 1'b1) begin errors++; $display("[TB] FAIL fair_dev_rst: got %b expected 1", dev_rst); end
      end
      if (c == 8) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL fair_end_busy: got %b expected 0", busy); end
      end
      @(posedge clk); #1;
    end
  endtask

  // Requester 3 drops after two bytes; ptr must wrap to 0 afterwards.
  task automatic test_drop();
    for (int c = 0; c < 9; c++) begin
      req_valid[3] = (c <= 3);
      req_valid[0] = (c == 5 || c == 6);
      req_valid[2] = (c == 5 || c == 6);
      req_valid[1] = 1'b0;
      req_data     = {8'hE0 + 8'(c), 8'h22, 8'h11, 8'h01};
      @(negedge clk);
      if (c == 1) begin
        checks++; if (grant !== 4'b1000) begin errors++; $display("[TB] FAIL drop_grant: got %b expected 1000", grant); end
      end
      if (c == 2 || c == 3) begin
        checks++; if ((req_ready & req_valid) !== 4'b1000) begin errors++; $display("[TB] FAIL drop_accept c%0d: got %b expected 1000", c, req_ready & req_valid); end
        checks++; if (dev_in !== 8'hE0 + 8'(c)) begin errors++; $display("[TB] FAIL drop_dev_in c%0d: got %h expected %h", c, dev_in, 8'hE0 + 8'(c)); end
      end
      if (c == 4) begin
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL drop_no_accept: got %b expected 0000", req_ready); end
        checks++; if (dev_in !== 8'h00) begin errors++; $display("[TB] FAIL drop_dev_in_zero: got %h expected 00", dev_in); end
      end
      if (c == 5) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_idle: got %b expected 0", busy); end
        checks++; if (resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL drop_resp_valid: got %b expected 0000", resp_valid); end
      end
      if (c == 6) begin
        checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL drop_ptr_grant: got %b expected 0001", grant); end
      end
      @(posedge clk); #1;
    end
  endtask

  // Two identical sessions from requester 0 must yield identical responses.
  task automatic test_determinism();
    logic [7:0] bytes [3];
    logic [7:0] exp_resp [3];
    bytes    = '{8'hA5, 8'h5A, 8'hFF};
    exp_resp = '{8'h99, 8'h47, 8'h6B};
    for (int run = 0; run < 2; run++) begin
      for (int c = 0; c < 7; c++) begin
        req_valid = (c <= 4) ? 4'b0001 : 4'b0000;
        req_data  = {24'h0, (c >= 2 && c <= 4) ? bytes[c-2] : 8'h00};
        @(negedge clk);
        if (c >= 3 && c <= 5) begin
          checks++; if (resp_valid !== 4'b0001) begin errors++; $display("[TB] FAIL det_resp_valid r%0d c%0d: got %b expected 0001", run, c, resp_valid); end
          checks++; if (resp_data !== exp_resp[c-3]) begin errors++; $display("[TB] FAIL det_resp_data r%0d c%0d: got %h expected %h", run, c, resp_data, exp_resp[c-3]); end
        end
        if (c == 6) begin
          checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL det_busy r%0d: got %b expected 0", run, busy); end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  // Reset asserted between edges mid-stream, then a fresh session from 0.
  task automatic test_async_reset();
    req_valid = 4'b0001;
    req_data  = 32'h00000042;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (dev_rst !== 1'b1) begin errors++; $display("[TB] FAIL arst_dev_rst: got %b expected 1", dev_rst); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL arst_grant: got %b expected 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL arst_busy: got %b expected 0", busy); end
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL arst_resp_valid: got %b expected 0000", resp_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL arst_req_ready: got %b expected 0000", req_ready); end
    checks++; if (resp_data !== 8'h00) begin errors++; $display("[TB] FAIL arst_resp_data: got %h expected 00", resp_data); end
    checks++; if (dev_in !== 8'h00) begin errors++; $display("[TB] FAIL arst_dev_in: got %h expected 00", dev_in); end
    #1 rst = 1'b0;
    req_valid = 4'b0011;
    req_data  = 32'h00007742;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL arst_regrant: got %b expected 0001", grant); end
    checks++; if (dev_rst !== 1'b1) begin errors++; $display("[TB] FAIL arst_restart: got %b expected 1", dev_rst); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ((req_ready & req_valid) !== 4'b0001) begin errors++; $display("[TB] FAIL arst_accept: got %b expected 0001", req_ready & req_valid); end
    checks++; if (dev_in !== 8'h42) begin errors++; $display("[TB] FAIL arst_dev_in2: got %h expected 42", dev_in); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (resp_valid !== 4'b0001) begin errors++; $display("[TB] FAIL arst_resp_valid2: got %b expected 0001", resp_valid); end
    checks++; if (resp_data !== 8'h7E) begin errors++; $display("[TB] FAIL arst_resp_data2: got %h expected 7e", resp_data); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL arst_end_busy: got %b expected 0", busy); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_drop();
    test_determinism();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
